// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter that sequences single-beat AHB transfers into the AHB-to-APB bridge.
// Optional data-phase watchdog enabled by defining ARB_TIMEOUT_EN.
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          Hclk,
    input  logic                          Hresetn,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic [NUM_MASTERS-1:0]        done,
    output logic                          err,
    output logic [DATA_W-1:0]             rdata,
    output logic                          timeout,
    output logic [ADDR_W-1:0]             Haddr,
    output logic [1:0]                    Htrans,
    output logic                          Hwrite,
    output logic [DATA_W-1:0]             Hwdata,
    output logic                          Hreadyin,
    input  logic                          Hreadyout,
    input  logic [1:0]                    Hresp,
    input  logic [DATA_W-1:0]             Hrdata
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [NUM_MASTERS-1:0]   done_q, done_d;
    logic                     err_q, err_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic [ADDR_W-1:0]        haddr_q, haddr_d;
    logic [1:0]               htrans_q, htrans_d;
    logic                     hwrite_q, hwrite_d;
    logic [DATA_W-1:0]        hwdata_q, hwdata_d;
    logic [DATA_W-1:0]        wdata_lat_q, wdata_lat_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]         rr_next_s;
    logic [PTR_W-1:0]         cand_s;
    logic [PTR_W-1:0]         win_idx_s;
    logic                     win_found_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                     timeout_q, timeout_d;
`endif

    // Round-robin search starting at rr_ptr with wrap-around
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand_s = PTR_W'((int'(rr_ptr_q) + i) % NUM_MASTERS);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Pointer just past the current owner, so the served master drops to lowest priority
    always_comb begin
        if (owner_q == PTR_W'(NUM_MASTERS - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = owner_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and registered-output logic for the transfer sequencer
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        wdata_lat_d = wdata_lat_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found_s) begin
                    grant_d     = ONE_HOT0 << win_idx_s;
                    owner_d     = win_idx_s;
                    haddr_d     = m_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
                    hwrite_d    = m_write[win_idx_s];
                    wdata_lat_d = m_wdata[int'(win_idx_s)*DATA_W +: DATA_W];
                    htrans_d    = HTRANS_NONSEQ;
                    state_d     = S_ADDR;
                end else begin
                    htrans_d    = HTRANS_IDLE;
                    state_d     = S_IDLE;
                end
            end
            S_ADDR: begin
                if (Hreadyout) begin
                    htrans_d  = HTRANS_IDLE;
                    hwdata_d  = wdata_lat_q;
                    state_d   = S_DATA;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    state_d   = S_ADDR;
                end
            end
            S_DATA: begin
                if (Hreadyout) begin
                    done_d   = grant_q;
                    err_d    = (Hresp != 2'b00);
                    if (!hwrite_q) begin
                        rdata_d = Hrdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    rr_ptr_d = rr_next_s;
                    grant_d  = '0;
                    state_d  = S_IDLE;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    // Abort a stalled data phase; rdata keeps its previous value
                    tmo_cnt_d = tmo_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        timeout_d = 1'b1;
                        done_d    = grant_q;
                        rr_ptr_d  = rr_next_s;
                        grant_d   = '0;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                    end
`else
                    state_d = S_DATA;
`endif
                end
            end
            default: begin
                state_d  = S_IDLE;
                grant_d  = '0;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by Hresetn
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            wdata_lat_q <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            wdata_lat_q <= wdata_lat_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign Haddr    = haddr_q;
    assign Htrans   = htrans_q;
    assign Hwrite   = hwrite_q;
    assign Hwdata   = hwdata_q;
    // Sole master on this port, so the bridge is never stalled from this side
    assign Hreadyin = 1'b1;
`ifdef ARB_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Scoreboard bench for ahb_bridge_arbiter: directed transfers push expected completions,
// a negedge monitor pops and compares whenever done/err is presented.
module tb_ahb_bridge_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            Hclk = 1'b0;
    logic            Hresetn;
    logic [N-1:0]    req;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_write;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            err;
    logic [DW-1:0]   rdata;
    logic            timeout;
    logic [AW-1:0]   Haddr;
    logic [1:0]      Htrans;
    logic            Hwrite;
    logic [DW-1:0]   Hwdata;
    logic            Hreadyin;
    logic            Hreadyout;
    logic [1:0]      Hresp;
    logic [DW-1:0]   Hrdata;

    ahb_bridge_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .req(req), .m_addr(m_addr), .m_write(m_write),
        .m_wdata(m_wdata), .grant(grant), .done(done), .err(err), .rdata(rdata),
        .timeout(timeout), .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hwdata(Hwdata),
        .Hreadyin(Hreadyin), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    always #5 Hclk = ~Hclk;

    typedef struct packed {
        logic [N-1:0]  done;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model_rdata;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic logic [N-1:0] onehot(int m);
        logic [N-1:0] v;
        v    = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    // Monitor: per-cycle invariants, and scoreboard pop on every completion
    always @(negedge Hclk) begin
        if (Hresetn) begin
            chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
            chk("timeout_low", 64'(timeout), 64'd0);
            if (done != '0 || err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: done=%b err=%b with nothing expected", done, err);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_done", 64'(done), 64'(mon_e.done));
                    chk("sb_err", 64'(err), 64'(mon_e.err));
                    chk("sb_rdata", 64'(rdata), 64'(mon_e.rdata));
                end
            end
        end
    end

    task automatic check_reset_values(string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_haddr"}, 64'(Haddr), 64'd0);
        chk({tag, "_htrans"}, 64'(Htrans), 64'd0);
        chk({tag, "_hwrite"}, 64'(Hwrite), 64'd0);
        chk({tag, "_hwdata"}, 64'(Hwdata), 64'd0);
        chk({tag, "_hreadyin"}, 64'(Hreadyin), 64'd1);
    endtask

    // One single-beat transfer with a bridge that stalls the data phase 'waits' cycles
    task automatic xfer(input int m, input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wdata, input int waits, input logic [1:0] resp,
                        input logic [DW-1:0] hrd, input bit drop, input logic [N-1:0] also);
        exp_t e;
        @(negedge Hclk);
        m_addr[m*AW +: AW]  = addr;
        m_write[m]          = wr;
        m_wdata[m*DW +: DW] = wdata;
        req                 = req | also;
        req[m]              = 1'b1;
        if (!wr) model_rdata = hrd;
        e.done  = onehot(m);
        e.err   = (resp != 2'b00);
        e.rdata = model_rdata;
        exp_q.push_back(e);
        @(negedge Hclk);
        chk("addr_grant", 64'(grant), 64'(onehot(m)));
        chk("addr_htrans", 64'(Htrans), 64'h2);
        chk("addr_haddr", 64'(Haddr), 64'(addr));
        chk("addr_hwrite", 64'(Hwrite), 64'(wr));
        @(negedge Hclk);
        chk("data_htrans", 64'(Htrans), 64'h0);
        chk("data_hwdata", 64'(Hwdata), 64'(wdata));
        chk("data_done_low", 64'(done), 64'd0);
        Hrdata = hrd;
        if (drop) begin
            req[m]              = 1'b0;
            m_addr[m*AW +: AW]  = ~addr;
            m_wdata[m*DW +: DW] = ~wdata;
            m_write[m]          = ~wr;
        end
        if (waits == 0) begin
            Hreadyout = 1'b1;
            Hresp     = resp;
        end else begin
            Hreadyout = 1'b0;
        end
        for (int w = 0; w < waits; w++) begin
            @(negedge Hclk);
            chk("wait_hwdata", 64'(Hwdata), 64'(wdata));
            chk("wait_haddr", 64'(Haddr), 64'(addr));
            chk("wait_grant", 64'(grant), 64'(onehot(m)));
            chk("wait_done_low", 64'(done), 64'd0);
            if (w == waits - 1) begin
                Hreadyout = 1'b1;
                Hresp     = resp;
            end
        end
        @(negedge Hclk);
        chk("done_latency", 64'(done), 64'(onehot(m)));
        chk("grant_cleared", 64'(grant), 64'd0);
        req   = '0;
        Hresp = 2'b00;
    endtask

    task automatic fairness();
        exp_t e;
        int   cyc;
        @(negedge Hclk);
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = 32'h8000_1000 + 32'(i * 4);
            m_write[i]          = 1'b0;
            m_wdata[i*DW +: DW] = '0;
        end
        Hrdata      = 32'hC0DE_0000;
        model_rdata = 32'hC0DE_0000;
        for (int t = 0; t < 8; t++) begin
            e.done  = onehot(t % N);
            e.err   = 1'b0;
            e.rdata = 32'hC0DE_0000;
            exp_q.push_back(e);
        end
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            cyc = 0;
            do begin
                @(negedge Hclk);
                cyc++;
            end while (grant == '0 && cyc < 8);
            chk("rr_grant_order", 64'(grant), 64'(onehot(t % N)));
            cyc = 0;
            while (done == '0 && cyc < 8) begin
                @(negedge Hclk);
                cyc++;
            end
            if (cyc >= 8) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rr_done_wait: no done within 8 cycles for transfer %0d", t);
            end
        end
        req = '0;
    endtask

    // Abort master 1 in a stalled data phase with an asynchronous reset
    task automatic reset_mid_data();
        @(negedge Hclk);
        m_addr[1*AW +: AW] = 32'h8000_0100;
        m_write[1]         = 1'b0;
        req[1]             = 1'b1;
        @(negedge Hclk);
        @(negedge Hclk);
        Hreadyout = 1'b0;
        @(negedge Hclk);
        chk("abort_in_data_grant", 64'(grant), 64'(onehot(1)));
        #2 Hresetn = 1'b0;
        #1 check_reset_values("async_rst");
        req         = '0;
        model_rdata = '0;
        @(negedge Hclk);
        Hresetn   = 1'b1;
        Hreadyout = 1'b1;
    endtask

    initial begin
        Hresetn   = 1'b0;
        req       = '0;
        m_addr    = '0;
        m_write   = '0;
        m_wdata   = '0;
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        Hrdata    = '0;
        model_rdata = '0;
        #12;
        check_reset_values("reset");
        @(negedge Hclk);
        Hresetn = 1'b1;

        fairness();
        xfer(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 0, 2'b00, 32'h0000_0000, 1'b0, 4'b0000);
        xfer(2, 32'h8000_0004, 1'b0, 32'h0000_0000, 2, 2'b00, 32'h1234_5678, 1'b1, 4'b0000);
        xfer(3, 32'h8000_0020, 1'b1, 32'h0BAD_F00D, 0, 2'b01, 32'h0000_0000, 1'b0, 4'b0000);
        xfer(0, 32'h8000_0030, 1'b0, 32'h0000_0000, 1, 2'b00, 32'hCAFE_0001, 1'b0, 4'b0000);
        // Pointer now sits at master 1; after reset master 0 must beat master 1
        reset_mid_data();
        xfer(0, 32'h8000_0040, 1'b0, 32'h0000_0000, 0, 2'b00, 32'h5555_AAAA, 1'b0, 4'b0010);
        repeat (3) @(negedge Hclk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
